// File: rtl/exu_mul_pipe.sv
// exu_mul_pipe: elastic STAGES-deep multiplier, 8 modes, valid/ready at both ends, flush kills in-flight ops.
// Optional EXU_MUL_PERF_EN adds perf_ops / perf_stall counters.
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif

module exu_mul_pipe #(
  parameter int STAGES = 3,
  parameter int TAG_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [`LA64_DATA_WIDTH-1:0] src1,
  input  logic [`LA64_DATA_WIDTH-1:0] src2,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [63:0]                 result,
  output logic [TAG_W-1:0]            out_tag
`ifdef EXU_MUL_PERF_EN
  ,
  output logic [31:0]                 perf_ops,
  output logic [31:0]                 perf_stall
`endif
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [2:0]        op_q   [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [127:0]      prod_q [1:STAGES-1];
  logic [64:0]       a_d, b_d, a_q, b_q;
  logic [127:0]      prod_d;

  // Stage i can load unless it and every stage after it are full while the consumer stalls.
  for (genvar i = 0; i < STAGES; i++) begin : g_ld
    assign ld[i] = out_ready | ~(&vld[STAGES-1:i]);
  end

  assign in_ready  = !rst && !flush && ld[0];
  assign out_valid = vld[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  always_comb begin
    a_d = {src1[63], src1};
    b_d = {src2[63], src2};
    case (op)
      3'b010: begin
        a_d = {1'b0, src1};
        b_d = {1'b0, src2};
      end
      3'b011, 3'b100, 3'b110: begin
        a_d = {{33{src1[31]}}, src1[31:0]};
        b_d = {{33{src2[31]}}, src2[31:0]};
      end
      3'b101, 3'b111: begin
        a_d = {33'd0, src1[31:0]};
        b_d = {33'd0, src2[31:0]};
      end
      default: ;
    endcase
  end

  // Low 128 bits of the 65x65 signed product; the exact product always fits.
  assign prod_d = {{63{a_q[64]}}, a_q} * {{63{b_q[64]}}, b_q};

  always_ff @(posedge clk) begin
    if (ld[0] && in_valid) begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q[0]  <= op;
      tag_q[0] <= in_tag;
    end
    if (ld[1] && vld[0]) begin
      prod_q[1] <= prod_d;
      op_q[1]   <= op_q[0];
      tag_q[1]  <= tag_q[0];
    end
    for (int i = 2; i < STAGES; i++) begin
      if (ld[i] && vld[i-1]) begin
        prod_q[i] <= prod_q[i-1];
        op_q[i]   <= op_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
    if (rst) begin
      vld                <= '0;
      prod_q[STAGES-1]   <= '0;
      op_q[STAGES-1]     <= '0;
      tag_q[STAGES-1]    <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (ld[0]) vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (ld[i]) vld[i] <= vld[i-1];
      end
    end
  end

  always_comb begin
    case (op_q[STAGES-1])
      3'b001, 3'b010: result = prod_q[STAGES-1][127:64];
      3'b011:         result = {{32{prod_q[STAGES-1][31]}}, prod_q[STAGES-1][31:0]};
      3'b100, 3'b101: result = {{32{prod_q[STAGES-1][63]}}, prod_q[STAGES-1][63:32]};
      default:        result = prod_q[STAGES-1][63:0];
    endcase
  end

`ifdef EXU_MUL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready)  perf_ops   <= perf_ops + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_mul_pipe.sv
// Bench for exu_mul_pipe: vector table, directed handshake/flush/reset sequences, randomized traffic vs a scoreboard.
module tb_exu_mul_pipe;
  localparam int S  = 3;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [63:0] src1, src2, result;
  logic [TW-1:0] in_tag, out_tag;
`ifdef EXU_MUL_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  exu_mul_pipe #(.STAGES(S), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
`ifdef EXU_MUL_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[10];

  int tests = 0, fails = 0, cyc = 0;
  int acc_cnt = 0, del_cnt = 0, stall_cnt = 0;
  logic [63:0]   exp_q[$];
  logic [TW-1:0] tag_q[$];
  int            acy_q[$];
  bit use_tbl = 0, lat_chk = 0, acc_flag = 0;
  logic [63:0] tbl_exp;
  bit p_stall = 0, p_flush = 0;
  logic [63:0] p_res;
  logic [TW-1:0] p_tag;

  // Reference: products from whole-number arithmetic on the operands as the mode interprets them.
  function automatic logic [63:0] ref_mul(logic [2:0] o, logic [63:0] x, logic [63:0] y);
    logic signed [127:0] sa, sb, ss;
    logic [127:0] ua, ub, uu;
    logic signed [63:0] wa, wb, ws;
    logic [63:0] tu;
    sa = {{64{x[63]}}, x};  sb = {{64{y[63]}}, y};  ss = sa * sb;
    ua = {64'd0, x};        ub = {64'd0, y};        uu = ua * ub;
    wa = {{32{x[31]}}, x[31:0]};  wb = {{32{y[31]}}, y[31:0]};  ws = wa * wb;
    tu = {32'd0, x[31:0]} * {32'd0, y[31:0]};
    case (o)
      3'b000:  return ss[63:0];
      3'b001:  return ss[127:64];
      3'b010:  return uu[127:64];
      3'b011:  return {{32{ws[31]}}, ws[31:0]};
      3'b100:  return {{32{ws[63]}}, ws[63:32]};
      3'b101:  return {{32{tu[63]}}, tu[63:32]};
      3'b110:  return ws;
      default: return tu;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom % 6)
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called once per cycle while inputs/outputs are stable, just before the rising edge.
  task automatic check();
    if (rst) begin
      exp_q.delete(); tag_q.delete(); acy_q.delete();
      p_stall = 0; p_flush = 0;
    end else begin
      if (p_stall && !p_flush) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", result, p_res);
        chk("hold_tag", 64'(out_tag), 64'(p_tag));
      end
      if (p_flush) chk("post_flush_empty", 64'(out_valid), 64'd0);
      if (flush) chk("flush_in_ready", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(use_tbl ? tbl_exp : ref_mul(op, src1, src2));
        tag_q.push_back(in_tag);
        acy_q.push_back(cyc);
        acc_cnt++;
        acc_flag = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          logic [TW-1:0] t;
          int ac;
          e = exp_q.pop_front(); t = tag_q.pop_front(); ac = acy_q.pop_front();
          chk("result", result, e);
          chk("out_tag", 64'(out_tag), 64'(t));
          if (lat_chk) chk("latency", 64'(cyc - ac), 64'(S));
        end
        del_cnt++;
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (flush) begin
        exp_q.delete(); tag_q.delete(); acy_q.delete();
      end
      p_stall = out_valid && !out_ready;
      p_res   = result;
      p_tag   = out_tag;
      p_flush = flush;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [2:0] o, logic [63:0] a, logic [63:0] b, logic [TW-1:0] t);
    in_valid = 1; op = o; src1 = a; src2 = b; in_tag = t;
    acc_flag = 0;
    for (int k = 0; k < 20 && !acc_flag; k++) step();
    if (!acc_flag) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1; flush = 0;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
    step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, del0, stl0;
`ifdef EXU_MUL_PERF_EN
    logic [31:0] po0, ps0;
`endif
    tbl[0] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[1] = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_0000_0001};
    tbl[3] = '{3'b100, 64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_FFFF_FFFF, 64'h0};
    tbl[4] = '{3'b101, 64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[5] = '{3'b111, 64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[6] = '{3'b011, 64'h1111_1111_8000_0000, 64'h2222_2222_0000_0003, 64'hFFFF_FFFF_8000_0000};
    tbl[7] = '{3'b110, 64'h5555_5555_FFFF_FFFE, 64'h0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFF2};
    tbl[8] = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    tbl[9] = '{3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    rst = 1; flush = 0; in_valid = 1; out_ready = 0; op = 0; src1 = 0; src2 = 0; in_tag = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 0; in_valid = 0;
    #1;
    chk("rst_in_ready_after", 64'(in_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);

    // Vector table, back-to-back with the consumer always ready.
    out_ready = 1; lat_chk = 1; use_tbl = 1;
    for (int i = 0; i < 10; i++) begin
      tbl_exp = tbl[i].exp;
      send(tbl[i].op, tbl[i].a, tbl[i].b, TW'(i));
    end
    drain();
    use_tbl = 0;

    // Ten back-to-back ops, tags 0..9: exact latency and 1/cycle throughput.
    for (int i = 0; i < 10; i++) send(3'($urandom), rnd64(), rnd64(), TW'(i));
    drain();

    // Consumer stalls 6 cycles under continuous requests.
    lat_chk = 0;
    acc0 = acc_cnt; del0 = del_cnt; stl0 = stall_cnt;
`ifdef EXU_MUL_PERF_EN
    po0 = perf_ops; ps0 = perf_stall;
`endif
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      op = 3'($urandom); src1 = rnd64(); src2 = rnd64(); in_tag = TW'(8'h40 + k);
      step();
    end
    chk("bp_accepts", 64'(acc_cnt - acc0), 64'd3);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    drain();
    chk("bp_delivered", 64'(del_cnt - del0), 64'd3);
`ifdef EXU_MUL_PERF_EN
    chk("perf_stall", 64'(perf_stall - ps0), 64'(stall_cnt - stl0));
    chk("perf_ops", 64'(perf_ops - po0), 64'(del_cnt - del0));
`endif

    // Flush with three ops in flight and a request pending: nothing delivered, nothing accepted.
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(3'($urandom), rnd64(), rnd64(), TW'(8'h80 + i));
    del0 = del_cnt; acc0 = acc_cnt;
    flush = 1; in_valid = 1; op = 3'b000; src1 = 64'd5; src2 = 64'd7; in_tag = 8'hEE;
    step();
    flush = 0; in_valid = 0;
    step();
    chk("flush_no_accept", 64'(acc_cnt - acc0), 64'd0);
    chk("flush_no_deliver", 64'(del_cnt - del0), 64'd0);
    out_ready = 1; lat_chk = 1;
    send(3'b110, 64'h0000_0001_FFFF_FFFD, 64'h0000_0002_0000_0009, 8'h5A);
    drain();

    // Flush coinciding with a delivery: output op delivered, the rest discarded.
    for (int i = 0; i < 3; i++) send(3'($urandom), rnd64(), rnd64(), TW'(8'h90 + i));
    del0 = del_cnt;
    in_valid = 0; flush = 1;
    step();
    flush = 0;
    step(); step();
    chk("flush_deliver_one", 64'(del_cnt - del0), 64'd1);
    lat_chk = 0;

    // Reset mid-operation together with flush.
    out_ready = 0;
    for (int i = 0; i < 2; i++) send(3'($urandom), rnd64(), rnd64(), TW'(8'hA0 + i));
    in_valid = 0; rst = 1; flush = 1;
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 0; flush = 0; out_ready = 1;
    del0 = del_cnt;
    repeat (4) step();
    chk("midrst_discard", 64'(del_cnt - del0), 64'd0);

    // Randomized traffic with random backpressure and occasional flush.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 32) == 0;
      op = 3'($urandom); src1 = rnd64(); src2 = rnd64(); in_tag = TW'($urandom);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
